// File: rtl/coin_input_debounce.sv
// Debounces the two active-low coin keys and emits one-cycle pulses that never coincide (half before one).
// Optional build macro COIN_CNT_EN adds the saturating coin_total accumulator output.

module coin_key_filter #(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_s_i,
    output logic press_o
);
    // state     | meaning
    // IDLE      | key released and stable
    // PRESS_FLT | key seen low, waiting for it to stay low for the window
    // PRESSED   | press accepted, key held
    // REL_FLT   | key seen high, waiting for it to stay high for the window
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_FLT = 2'd1,
        PRESSED   = 2'd2,
        REL_FLT   = 2'd3
    } state_t;

    state_t      state_q;
    logic [19:0] cnt_q;
    logic        cnt_done;

    assign cnt_done = (cnt_q == CNT_MAX - 20'd1);

    // Combinational so the output pulse register can capture it on the accepting edge.
    assign press_o = (state_q == PRESS_FLT) && !key_s_i && cnt_done;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= 20'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!key_s_i) begin
                        state_q <= PRESS_FLT;
                        cnt_q   <= 20'd1;
                    end
                end
                PRESS_FLT: begin
                    if (key_s_i) begin
                        state_q <= IDLE;
                        cnt_q   <= 20'd0;
                    end else if (cnt_done) begin
                        state_q <= PRESSED;
                        cnt_q   <= 20'd0;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                PRESSED: begin
                    if (key_s_i) begin
                        state_q <= REL_FLT;
                        cnt_q   <= 20'd1;
                    end
                end
                REL_FLT: begin
                    if (!key_s_i) begin
                        state_q <= PRESSED;
                        cnt_q   <= 20'd0;
                    end else if (cnt_done) begin
                        state_q <= IDLE;
                        cnt_q   <= 20'd0;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 20'd0;
                end
            endcase
        end
    end
endmodule

module coin_input_debounce #(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_half,
    input  logic       key_one,
    output logic       po_money_half,
    output logic       po_money_one
`ifdef COIN_CNT_EN
    ,
    output logic [7:0] coin_total
`endif
);
    logic [1:0] half_sync_q;
    logic [1:0] one_sync_q;
    logic       ev_half;
    logic       ev_one;
    logic       half_q, half_d;
    logic       one_q, one_d;
    logic       pend_one_q, pend_one_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            half_sync_q <= 2'b11;
            one_sync_q  <= 2'b11;
        end else begin
            half_sync_q <= {half_sync_q[0], key_half};
            one_sync_q  <= {one_sync_q[0], key_one};
        end
    end

    coin_key_filter #(.CNT_MAX(CNT_MAX)) u_half_flt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_s_i (half_sync_q[1]),
        .press_o (ev_half)
    );

    coin_key_filter #(.CNT_MAX(CNT_MAX)) u_one_flt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_s_i (one_sync_q[1]),
        .press_o (ev_one)
    );

    // Half always wins the slot; a colliding one-coin is parked and issued next cycle.
    always_comb begin
        half_d     = ev_half;
        one_d      = (ev_one || pend_one_q) && !ev_half;
        pend_one_d = (ev_one || pend_one_q) && ev_half;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            half_q     <= 1'b0;
            one_q      <= 1'b0;
            pend_one_q <= 1'b0;
        end else begin
            half_q     <= half_d;
            one_q      <= one_d;
            pend_one_q <= pend_one_d;
        end
    end

    assign po_money_half = half_q;
    assign po_money_one  = one_q;

`ifdef COIN_CNT_EN
    logic [7:0] total_q, total_d;
    logic [1:0] total_inc;
    logic [8:0] total_sum;

    always_comb begin
        total_inc = 2'd0;
        if (half_q) begin
            total_inc = 2'd1;
        end else if (one_q) begin
            total_inc = 2'd2;
        end
        total_sum = {1'b0, total_q} + {7'd0, total_inc};
        total_d   = total_sum[8] ? 8'hFF : total_sum[7:0];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            total_q <= 8'd0;
        end else begin
            total_q <= total_d;
        end
    end

    assign coin_total = total_q;
`endif
endmodule

// File: tb/tb_coin_input_debounce.sv
// Directed bench for coin_input_debounce with a 4-clock debounce window.
// Pulse times are hand-derived: key driven low after posedge k gives a pulse seen at cycle k+6.

module tb_coin_input_debounce;
    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       key_half;
    logic       key_one;
    logic       po_money_half;
    logic       po_money_one;
`ifdef COIN_CNT_EN
    logic [7:0] coin_total;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int cyc       = 0;
    int half_cnt  = 0;
    int one_cnt   = 0;
    int half_last = -1;
    int one_last  = -1;
    int overlap   = 0;

    coin_input_debounce #(.CNT_MAX(20'd4)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .key_half      (key_half),
        .key_one       (key_one),
        .po_money_half (po_money_half),
        .po_money_one  (po_money_one)
`ifdef COIN_CNT_EN
        ,
        .coin_total    (coin_total)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (po_money_half) begin
            half_cnt  = half_cnt + 1;
            half_last = cyc;
        end
        if (po_money_one) begin
            one_cnt  = one_cnt + 1;
            one_last = cyc;
        end
        if (po_money_half && po_money_one) overlap = overlap + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    int t0, t1, h0, o0;
    bit found;

    initial begin
        sys_rst  = 1'b1;
        key_half = 1'b1;
        key_one  = 1'b1;
        step(3);
        check_val("rst_half", 32'(po_money_half), 32'd0);
        check_val("rst_one", 32'(po_money_one), 32'd0);
`ifdef COIN_CNT_EN
        check_val("rst_total", 32'(coin_total), 32'd0);
`endif
        sys_rst = 1'b0;
        step(2);

        // 1: clean half press held 20 cycles
        h0 = half_cnt; o0 = one_cnt;
        key_half = 1'b0; t0 = cyc;
        step(5);
        check_val("t1_no_early", half_cnt - h0, 0);
        step(15);
        check_val("t1_half_count", half_cnt - h0, 1);
        check_val("t1_half_time", half_last, t0 + 6);
        check_val("t1_one_quiet", one_cnt - o0, 0);
        key_half = 1'b1;
        step(10);

        // 2: bouncing one key, then steady low
        h0 = half_cnt; o0 = one_cnt;
        repeat (4) begin
            key_one = 1'b0; step(2);
            key_one = 1'b1; step(1);
        end
        step(4);
        check_val("t2_bounce_rej", one_cnt - o0, 0);
        key_one = 1'b0; t0 = cyc;
        step(12);
        check_val("t2_one_count", one_cnt - o0, 1);
        check_val("t2_one_time", one_last, t0 + 6);
        check_val("t2_half_quiet", half_cnt - h0, 0);
        key_one = 1'b1;
        step(10);

        // press window boundary: 3 low samples reject, 4 accept
        o0 = one_cnt;
        key_one = 1'b0; step(3);
        key_one = 1'b1; step(8);
        check_val("bnd_low3", one_cnt - o0, 0);
        key_one = 1'b0; t0 = cyc; step(4);
        key_one = 1'b1; step(8);
        check_val("bnd_low4", one_cnt - o0, 1);
        check_val("bnd_low4_time", one_last, t0 + 6);

        // 3: simultaneous press
        h0 = half_cnt; o0 = one_cnt;
        key_half = 1'b0; key_one = 1'b0; t0 = cyc;
        step(14);
        check_val("t3_half_count", half_cnt - h0, 1);
        check_val("t3_one_count", one_cnt - o0, 1);
        check_val("t3_half_time", half_last, t0 + 6);
        check_val("t3_one_time", one_last, t0 + 7);
        key_half = 1'b1; key_one = 1'b1;
        step(10);

        // 4: release bounce, 4-high release accepted, 3-high release rejected
        h0 = half_cnt;
        key_half = 1'b0; step(10);
        repeat (3) begin
            key_half = 1'b1; step(1);
            key_half = 1'b0; step(1);
        end
        step(4);
        check_val("t4_bounce_quiet", half_cnt - h0, 1);
        key_half = 1'b1; step(4);
        key_half = 1'b0; t0 = cyc;
        step(12);
        check_val("t4_two_pulses", half_cnt - h0, 2);
        check_val("t4_second_time", half_last, t0 + 6);
        key_half = 1'b1; step(3);
        key_half = 1'b0; step(12);
        check_val("t4_short_release", half_cnt - h0, 2);
        key_half = 1'b1; step(10);

        // 5: reset while half pulse high and one pending
        key_half = 1'b0; key_one = 1'b0; t0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (po_money_half) begin
                found = 1'b1;
                break;
            end
        end
        check_val("t5_found_pulse", 32'(found), 32'd1);
        check_val("t5_pulse_time", cyc, t0 + 6);
        #2 sys_rst = 1'b1;
        #1;
        check_val("t5_rst_half", 32'(po_money_half), 32'd0);
        check_val("t5_rst_one", 32'(po_money_one), 32'd0);
        step(2);
        check_val("t5_pend_drop", 32'(po_money_one), 32'd0);
        sys_rst = 1'b0;
        t1 = cyc; h0 = half_cnt; o0 = one_cnt;
        step(12);
        check_val("t5_half_count", half_cnt - h0, 1);
        check_val("t5_half_time", half_last, t1 + 6);
        check_val("t5_one_count", one_cnt - o0, 1);
        check_val("t5_one_time", one_last, t1 + 7);
        key_half = 1'b1; key_one = 1'b1;
        step(10);

        check_val("no_overlap", overlap, 0);

`ifdef COIN_CNT_EN
        // 6: accumulator and saturation
        sys_rst = 1'b1; step(2);
        sys_rst = 1'b0; step(2);
        repeat (3) begin
            key_half = 1'b0; step(6);
            key_half = 1'b1; step(8);
        end
        check_val("t6_three_half", 32'(coin_total), 32'd3);
        repeat (2) begin
            key_one = 1'b0; step(6);
            key_one = 1'b1; step(8);
        end
        check_val("t6_total7", 32'(coin_total), 32'd7);
        repeat (124) begin
            key_one = 1'b0; step(6);
            key_one = 1'b1; step(8);
        end
        check_val("t6_reach255", 32'(coin_total), 32'd255);
        repeat (6) begin
            key_one = 1'b0; step(6);
            key_one = 1'b1; step(8);
        end
        check_val("t6_hold255", 32'(coin_total), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/coin_input_debounce.md
Name: coin_input_debounce

Overview:
Front-end stage for the vending-machine coin FSM. It takes two raw, bouncing, active-low coin buttons (half coin and one coin) and produces clean one-cycle pulses. Its two outputs drive the vending FSM's `pi_money_half` and `pi_money_one` inputs directly. It guarantees that the two outputs are never high in the same cycle, which is the invariant the downstream FSM relies on.

Parameters:
- CNT_MAX, 20'd999_999, debounce window in clocks (20 ms at 50 MHz). Legal range is 2 to 2^20-1.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  asynchronous reset, active-high.
- key_half  input  1  raw half-coin button, active-low, asynchronous to sys_clk.
- key_one  input  1  raw one-coin button, active-low, asynchronous to sys_clk.
- po_money_half  output  1  one-cycle pulse per accepted half coin.
- po_money_one  output  1  one-cycle pulse per accepted one coin.
- coin_total  output  8  accepted value in half-coin units. Present only with COIN_CNT_EN.

Behaviour:
- One clock domain: sys_clk. Reset is asynchronous and active-high (sys_rst). All flops use the same reset.
- Reset values:
  - Both 2-FF synchronisers: 1 (released).
  - Channel FSMs: IDLE. Counters: 0.
  - po_money_half, po_money_one, pend_one: 0.
  - coin_total: 0.
- Synchronisers: each key passes through 2 flops before any logic.
- Per-channel FSM. Two identical instances, acting on the synchronised level s. Each has a 20-bit counter cnt.
  - IDLE: s=0 -> PRESS_FLT, cnt<=1. Otherwise stay.
  - PRESS_FLT:
    - s=1 -> IDLE, cnt<=0 (bounce rejected, no event).
    - s=0 and cnt==CNT_MAX-1 -> PRESSED, cnt<=0, assert the channel's press event for this edge.
    - Otherwise cnt<=cnt+1.
  - PRESSED: s=1 -> REL_FLT, cnt<=1. Otherwise stay. Holding the key generates no further events.
  - REL_FLT:
    - s=0 -> PRESSED, cnt<=0 (release bounce, no new event).
    - s=1 and cnt==CNT_MAX-1 -> IDLE, cnt<=0.
    - Otherwise cnt<=cnt+1.
  - Any illegal state encoding -> IDLE.
- Latency: let e0 be the first edge that samples the raw key low, with the key held low from then on. The pulse register is set at edge e0+CNT_MAX+1 and cleared at the next edge. Pulse width is exactly 1 cycle.
- Output arbitration, registered:
  - Half event only: po_money_half<=1.
  - One event only, or pend_one set: po_money_one<=1, pend_one<=0.
  - Half and one events on the same edge: po_money_half<=1 and pend_one<=1. po_money_one then pulses on the following edge, so half is always first.
  - po_money_half and po_money_one are never 1 in the same cycle.
  - No coin is lost. pend_one cannot overflow, because a new one-coin event needs at least 2*CNT_MAX cycles.
- Reset mid-filter or mid-pulse: everything returns to reset values at once. A pending one is discarded. A key still held low after reset is released is treated as a fresh press and is re-debounced.

Optional Feature:
- Macro: COIN_CNT_EN.
- Defined:
  - coin_total port exists.
  - It adds 1 on each po_money_half pulse and 2 on each po_money_one pulse, updating on the edge after the pulse is set.
  - It saturates at 255 and never wraps. Reset clears it to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan (CNT_MAX=4 in all cases):
1. Clean half press: key_half low from edge e0 and held for 20 cycles -> po_money_half high only after edge e0+5, for 1 cycle. po_money_one stays 0. No second pulse while held.
2. Bounce reject: key_one toggles low for 2 cycles, high for 1, four times -> no pulse. A final steady low then gives exactly one po_money_one pulse.
3. Simultaneous: both keys fall on the same edge e0 -> po_money_half after e0+5 and po_money_one after e0+6, each for 1 cycle, never overlapping.
4. Release bounce: after an accepted press, key_half toggles 1/0 for 3 cycles during release, then presses again after a full 4-cycle release -> exactly 2 pulses in total.
5. Reset mid-operation: assert sys_rst while pend_one=1, or on the cycle a pulse is high -> all outputs 0 at once. With the key still low after release, a pulse occurs at e0'+5, where e0' is the first edge after reset release.
6. COIN_CNT_EN: 3 half coins and 2 one coins -> coin_total=7. Then 130 one coins -> coin_total=255 and holds there.
